// File: rtl/judge_pkg.sv
// judge_pkg: types and constants shared by the frame judge sequencer
// (judge_frame_ctrl) and its debounce stage (judge_debounce).
//   - colour codes for the 2-bit frame decision / published result
//   - FSM state encoding for the frame sequencer
//   - streak counter width (CONFIRM is limited to 1..15)
package judge_pkg;

    localparam logic [1:0] COL_NONE  = 2'b00;
    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_GREEN = 2'b10;

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

endpackage

// File: rtl/judge_debounce.sv
// judge_debounce: multi-frame debounce of the per-frame colour decision.
// Keeps a candidate colour and a streak of consecutive identical decisions;
// the published result switches to the candidate once the streak reaches
// CONFIRM.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         run disabled: drop candidate/streak, force result to none
//   abort         frame aborted: restart the streak, keep the result
//   decide        one-cycle strobe carrying a completed frame decision
//   decision[1:0] colour decided for the frame that just ended
//   result[1:0]   debounced colour
//   result_valid  one-cycle pulse per decided frame
module judge_debounce
    import judge_pkg::*;
#(
    parameter int unsigned CONFIRM = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       abort,
    input  logic       decide,
    input  logic [1:0] decision,
    output logic [1:0] result,
    output logic       result_valid
);

    localparam logic [STREAK_W-1:0] CONF = STREAK_W'(CONFIRM);

    logic [1:0]          cand;
    logic [1:0]          cand_next;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;

    always_comb begin
        cand_next   = cand;
        streak_next = streak;
        if (decision == cand) begin
            streak_next = (streak >= CONF) ? CONF : streak + 1'b1;
        end else begin
            cand_next   = decision;
            streak_next = STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand         <= COL_NONE;
            streak       <= '0;
            result       <= COL_NONE;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (clear) begin
                cand   <= COL_NONE;
                streak <= '0;
                result <= COL_NONE;
            end else if (abort) begin
                streak <= '0;
            end else if (decide) begin
                cand         <= cand_next;
                streak       <= streak_next;
                result_valid <= 1'b1;
                if (streak_next == CONF) begin
                    result <= cand_next;
                end
            end
        end
    end

endmodule

// File: rtl/judge_frame_ctrl.sv
// judge_frame_ctrl: frame-level sequencer for the red/green pixel classifier.
// Tracks the pixel position from pix_valid, counts classifier hits inside a
// programmable ROI, decides red/green/none once per frame and hands the
// decision to judge_debounce, which publishes a stable colour code.
// Optional build macro: JUDGE_FRAME_DBG_CNT_EN adds dbg_r_cnt/dbg_g_cnt,
// snapshots of the hit counters taken at each frame decision.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          run enable; low returns to IDLE and clears the result
//   frame_start     one-cycle start-of-frame pulse
//   pix_valid       active pixel present this cycle
//   red_hit         classifier red flag for the current pixel
//   green_hit       classifier green flag for the current pixel
//   result[1:0]     debounced colour: 00 none, 01 red, 10 green
//   result_valid    one-cycle pulse after every completed frame
//   busy            high in ACCUM or DECIDE
//   dbg_r_cnt/dbg_g_cnt  (macro only) counter snapshots from the last decision
module judge_frame_ctrl
    import judge_pkg::*;
#(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int ROI_X0  = 0,
    parameter int ROI_X1  = 639,
    parameter int ROI_Y0  = 0,
    parameter int ROI_Y1  = 479,
    parameter int CNT_W   = 16,
    parameter int THRESH  = 200,
    parameter int CONFIRM = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic       red_hit,
    input  logic       green_hit,
    output logic [1:0] result,
    output logic       result_valid,
    output logic       busy
`ifdef JUDGE_FRAME_DBG_CNT_EN
    ,
    output logic [CNT_W-1:0] dbg_r_cnt,
    output logic [CNT_W-1:0] dbg_g_cnt
`endif
);

    localparam int X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

    state_t           state;
    state_t           state_next;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] g_cnt;

    logic start_frame;
    logic accept;
    logic decide;
    logic abort;
    logic clear;
    logic x_last;
    logic y_last;
    logic in_roi;
    logic [1:0] decision;

    // Signed 32-bit copies so ROI bounds of 0 do not produce always-true
    // unsigned comparisons.
    int x_i;
    int y_i;
    assign x_i = int'(x);
    assign y_i = int'(y);

    assign x_last = (x == X_W'(H_ACT - 1));
    assign y_last = (y == Y_W'(V_ACT - 1));
    assign in_roi = (x_i >= ROI_X0) && (x_i <= ROI_X1) &&
                    (y_i >= ROI_Y0) && (y_i <= ROI_Y1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // frame_start in ACCUM takes priority over a coincident pixel: the frame
    // is aborted and that pixel is dropped.  frame_start in DECIDE skips WAIT.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        accept      = 1'b0;
        decide      = 1'b0;
        abort       = 1'b0;
        clear       = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
            clear      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (frame_start) begin
                        start_frame = 1'b1;
                        state_next  = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (frame_start) begin
                        start_frame = 1'b1;
                        abort       = 1'b1;
                    end else if (pix_valid) begin
                        accept = 1'b1;
                        if (x_last && y_last) begin
                            state_next = ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    decide = 1'b1;
                    if (frame_start) begin
                        start_frame = 1'b1;
                        state_next  = ST_ACCUM;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_ACCUM) || (state == ST_DECIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            r_cnt <= '0;
            g_cnt <= '0;
        end else if (clear || start_frame) begin
            x     <= '0;
            y     <= '0;
            r_cnt <= '0;
            g_cnt <= '0;
        end else if (accept) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            if (in_roi && red_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (in_roi && green_hit && (g_cnt != '1)) begin
                g_cnt <= g_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        decision = COL_NONE;
        if ((r_cnt >= CNT_W'(THRESH)) && (r_cnt > g_cnt)) begin
            decision = COL_RED;
        end else if ((g_cnt >= CNT_W'(THRESH)) && (g_cnt > r_cnt)) begin
            decision = COL_GREEN;
        end
    end

    judge_debounce #(
        .CONFIRM (CONFIRM)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .abort        (abort),
        .decide       (decide),
        .decision     (decision),
        .result       (result),
        .result_valid (result_valid)
    );

`ifdef JUDGE_FRAME_DBG_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_r_cnt <= '0;
            dbg_g_cnt <= '0;
        end else if (decide) begin
            dbg_r_cnt <= r_cnt;
            dbg_g_cnt <= g_cnt;
        end
    end
`endif

endmodule
